// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a word-wide data memory.
// Sub-word stores go through a read-modify-write of the containing word.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    LD,
    ST,
    RMW_RD,
    RMW_WR,
    RESP,
    ERR
  } state_t;

  state_t      state_q;
  op_t         op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        we_q;

  op_t         op_in;
  logic        misaligned_d;
  logic        is_load_d;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext_d;
  logic [31:0] merged_d;

  assign op_in = op_t'(op);

  always_comb begin
    misaligned_d = 1'b0;
    is_load_d    = 1'b0;
    case (op_in)
      OP_LW:                misaligned_d = (addr[1:0] != 2'b00);
      OP_SW:                misaligned_d = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned_d = addr[0];
      default:              misaligned_d = 1'b0;
    endcase
    case (op_in)
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: is_load_d = 1'b1;
      default:                             is_load_d = 1'b0;
    endcase
  end

  // Lane selection is little-endian on the latched address.
  always_comb begin
    byte_v     = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_v     = dm_rdata[{addr_q[1], 4'b0000} +: 16];
    load_ext_d = dm_rdata;
    case (op_q)
      OP_LH:   load_ext_d = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_ext_d = {16'h0000, half_v};
      OP_LB:   load_ext_d = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_ext_d = {24'h000000, byte_v};
      default: load_ext_d = dm_rdata;
    endcase
  end

  always_comb begin
    merged_d = merge_q;
    if (op_q == OP_SB) begin
      merged_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (op_q == OP_SH) begin
      merged_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (req) begin
            op_q    <= op_in;
            addr_q  <= addr;
            wdata_q <= wdata;
            busy_q  <= 1'b1;
            if (misaligned_d) begin
              state_q <= ERR;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (is_load_d) begin
              state_q <= LD;
            end else if (op_in == OP_SW) begin
              state_q <= ST;
              we_q    <= 1'b1;
            end else begin
              state_q <= RMW_RD;
            end
          end
        end
        LD: begin
          rdata_q <= load_ext_d;
          done_q  <= 1'b1;
          state_q <= RESP;
        end
        ST: begin
          we_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= RESP;
        end
        RMW_RD: begin
          merge_q <= dm_rdata;
          we_q    <= 1'b1;
          state_q <= RMW_WR;
        end
        RMW_WR: begin
          we_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= RESP;
        end
        RESP, ERR: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign addr_err = err_q;
  assign rdata    = rdata_q;
  assign dm_we    = we_q;
  assign dm_addr  = {addr_q[31:2], 2'b00};
  assign dm_wdata = (state_q == RMW_WR) ? merged_d : wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset-abort sequence and
// random traffic checked against a byte-array memory model.
module tb_mem_access_unit;

  localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                         LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

  logic        clk, reset, req;
  logic [2:0]  op;
  logic [31:0] addr, wdata;
  logic        busy, done, addr_err, dm_we;
  logic [31:0] rdata, dm_addr, dm_wdata, dm_rdata;

  logic [31:0] mem [64];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  logic [7:0]  rb [256];
  logic [31:0] ref_last;
  logic        after_done;

  int unsigned n_checks, n_fail;

  mem_access_unit dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .op       (op),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .addr_err (addr_err),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_we    (dm_we),
    .dm_rdata (dm_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign dm_rdata = mem[dm_addr[7:2]];

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr[7:2]] <= dm_wdata;
    else if (pre_we) mem[pre_idx] <= pre_val;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rb_word(input int unsigned base);
    return {rb[base+3], rb[base+2], rb[base+1], rb[base]};
  endfunction

  task automatic poke(input int unsigned idx, input logic [31:0] val);
    pre_we  = 1'b1;
    pre_idx = idx[5:0];
    pre_val = val;
    @(posedge clk);
    #1 pre_we = 1'b0;
    for (int b = 0; b < 4; b++) rb[idx*4 + b] = val[8*b +: 8];
    @(negedge clk);
    after_done = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge of the done cycle.
  task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] wd, output int unsigned lat, output logic err,
                       output logic [31:0] rd, output int unsigned we_cnt,
                       output logic [31:0] we_data);
    int unsigned edges, exp_edges;
    logic acc, got_done, addr_bad, busy_bad, idle_bad;
    exp_edges = after_done ? 2 : 1;
    req = 1'b1; op = o; addr = a; wdata = wd;
    edges = 0; acc = 1'b0; lat = 0; err = 1'b0; rd = '0; we_cnt = 0; we_data = '0;
    got_done = 1'b0; addr_bad = 1'b0; busy_bad = 1'b0; idle_bad = 1'b0;
    while (!acc && edges < 4) begin
      @(posedge clk);
      #1 edges++;
      if (busy === 1'b1) acc = 1'b1;
      else if (done !== 1'b0 || addr_err !== 1'b0 || dm_we !== 1'b0) idle_bad = 1'b1;
    end
    req = 1'b0;
    chk({nm, "_accepted"}, {31'b0, acc}, 32'd1);
    chk({nm, "_accept_edges"}, edges, exp_edges);
    chk({nm, "_idle_quiet"}, {31'b0, idle_bad}, 32'd0);
    if (!acc) begin
      @(negedge clk);
    end else begin
      while (!got_done && lat < 8) begin
        @(negedge clk);
        lat++;
        if (dm_we === 1'b1) begin
          we_cnt++;
          we_data = dm_wdata;
        end
        if (dm_addr !== {a[31:2], 2'b00}) addr_bad = 1'b1;
        if (busy !== 1'b1) busy_bad = 1'b1;
        if (done === 1'b1) begin
          got_done = 1'b1;
          err = addr_err;
          rd  = rdata;
        end
      end
      chk({nm, "_done_seen"}, {31'b0, got_done}, 32'd1);
      chk({nm, "_dm_addr_stable"}, {31'b0, addr_bad}, 32'd0);
      chk({nm, "_busy_held"}, {31'b0, busy_bad}, 32'd0);
    end
    after_done = got_done;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre_en;
    logic [31:0] pre_word;
    logic [31:0] exp_rd;
    logic        exp_err;
    int unsigned exp_lat;
    int unsigned exp_we;
    logic [31:0] exp_wd;
    logic [31:0] exp_mem;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                              input logic pe, input logic [31:0] pw, input logic [31:0] rd,
                              input logic e, input int unsigned l, input int unsigned w,
                              input logic [31:0] xwd, input logic [31:0] xm);
    vec_t v;
    v.op = o; v.addr = a; v.wdata = wd; v.pre_en = pe; v.pre_word = pw;
    v.exp_rd = rd; v.exp_err = e; v.exp_lat = l; v.exp_we = w; v.exp_wd = xwd; v.exp_mem = xm;
    return v;
  endfunction

  initial begin
    vec_t        tv [20];
    int unsigned lat, we_cnt;
    logic        err, bad;
    logic [31:0] rd, we_data;

    n_checks = 0; n_fail = 0;
    reset = 1'b0; req = 1'b0; op = '0; addr = '0; wdata = '0;
    pre_we = 1'b0; pre_idx = '0; pre_val = '0; after_done = 1'b0;

    tv[0]  = mk(LB,  32'h12, 32'h0, 1'b0, 32'h0, 32'hFFFFFF99, 1'b0, 2, 0, 32'h0, 32'h8899AABB);
    tv[1]  = mk(LBU, 32'h12, 32'h0, 1'b0, 32'h0, 32'h00000099, 1'b0, 2, 0, 32'h0, 32'h8899AABB);
    tv[2]  = mk(LH,  32'h12, 32'h0, 1'b0, 32'h0, 32'hFFFF8899, 1'b0, 2, 0, 32'h0, 32'h8899AABB);
    tv[3]  = mk(LHU, 32'h10, 32'h0, 1'b0, 32'h0, 32'h0000AABB, 1'b0, 2, 0, 32'h0, 32'h8899AABB);
    tv[4]  = mk(LW,  32'h10, 32'h0, 1'b0, 32'h0, 32'h8899AABB, 1'b0, 2, 0, 32'h0, 32'h8899AABB);
    tv[5]  = mk(LW,  32'h13, 32'h0, 1'b0, 32'h0, 32'h8899AABB, 1'b1, 1, 0, 32'h0, 32'h8899AABB);
    tv[6]  = mk(SB,  32'h21, 32'hFFFFFFA5, 1'b1, 32'h11223344, 32'h8899AABB, 1'b0, 3, 1, 32'h1122A544, 32'h1122A544);
    tv[7]  = mk(SH,  32'h22, 32'h0000BEEF, 1'b1, 32'h11223344, 32'h8899AABB, 1'b0, 3, 1, 32'hBEEF3344, 32'hBEEF3344);
    tv[8]  = mk(SH,  32'h21, 32'h00001234, 1'b0, 32'h0, 32'h8899AABB, 1'b1, 1, 0, 32'h0, 32'hBEEF3344);
    tv[9]  = mk(SW,  32'h24, 32'hDEADBEEF, 1'b0, 32'h0, 32'h8899AABB, 1'b0, 2, 1, 32'hDEADBEEF, 32'hDEADBEEF);
    tv[10] = mk(LB,  32'h23, 32'h0, 1'b0, 32'h0, 32'hFFFFFFBE, 1'b0, 2, 0, 32'h0, 32'hBEEF3344);
    tv[11] = mk(LH,  32'h22, 32'h0, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 0, 32'h0, 32'hBEEF3344);
    tv[12] = mk(LHU, 32'h22, 32'h0, 1'b0, 32'h0, 32'h0000BEEF, 1'b0, 2, 0, 32'h0, 32'hBEEF3344);
    tv[13] = mk(LBU, 32'h13, 32'h0, 1'b0, 32'h0, 32'h00000088, 1'b0, 2, 0, 32'h0, 32'h8899AABB);
    tv[14] = mk(LB,  32'h11, 32'h0, 1'b0, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0, 32'h0, 32'h8899AABB);
    tv[15] = mk(SW,  32'h26, 32'h12345678, 1'b0, 32'h0, 32'hFFFFFFAA, 1'b1, 1, 0, 32'h0, 32'hDEADBEEF);
    tv[16] = mk(SB,  32'h27, 32'h00000012, 1'b0, 32'h0, 32'hFFFFFFAA, 1'b0, 3, 1, 32'h12ADBEEF, 32'h12ADBEEF);
    tv[17] = mk(LW,  32'h24, 32'h0, 1'b0, 32'h0, 32'h12ADBEEF, 1'b0, 2, 0, 32'h0, 32'h12ADBEEF);
    tv[18] = mk(LB,  32'h27, 32'h0, 1'b0, 32'h0, 32'h00000012, 1'b0, 2, 0, 32'h0, 32'h12ADBEEF);
    tv[19] = mk(LHU, 32'h26, 32'h0, 1'b0, 32'h0, 32'h000012AD, 1'b0, 2, 0, 32'h0, 32'h12ADBEEF);

    // Memory image is loaded while the DUT is still held in reset.
    @(negedge clk);
    for (int unsigned i = 0; i < 64; i++) poke(i, $urandom);
    poke(4, 32'h8899AABB);
    poke(8, 32'h11223344);
    chk("rst_busy",     {31'b0, busy},     32'd0);
    chk("rst_done",     {31'b0, done},     32'd0);
    chk("rst_addr_err", {31'b0, addr_err}, 32'd0);
    chk("rst_dm_we",    {31'b0, dm_we},    32'd0);
    chk("rst_rdata",    rdata,             32'd0);
    chk("rst_dm_addr",  dm_addr,           32'd0);
    chk("rst_dm_wdata", dm_wdata,          32'd0);
    reset = 1'b1;
    after_done = 1'b0;

    for (int i = 0; i < 20; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      if (tv[i].pre_en) poke(tv[i].addr[7:2], tv[i].pre_word);
      do_op(nm, tv[i].op, tv[i].addr, tv[i].wdata, lat, err, rd, we_cnt, we_data);
      chk({nm, "_addr_err"}, {31'b0, err}, {31'b0, tv[i].exp_err});
      chk({nm, "_latency"}, lat, tv[i].exp_lat);
      chk({nm, "_rdata"}, rd, tv[i].exp_rd);
      chk({nm, "_we_cycles"}, we_cnt, tv[i].exp_we);
      if (tv[i].exp_we != 0) chk({nm, "_dm_wdata"}, we_data, tv[i].exp_wd);
      chk({nm, "_mem_word"}, mem[tv[i].addr[7:2]], tv[i].exp_mem);
    end

    // Reset during RMW_RD must abort with no write and no done pulse.
    poke(8, 32'h11223344);
    req = 1'b1; op = SB; addr = 32'h21; wdata = 32'hFFFFFFA5;
    @(posedge clk);
    #1 req = 1'b0;
    chk("abort_busy_before", {31'b0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy",     {31'b0, busy},  32'd0);
    chk("abort_done",     {31'b0, done},  32'd0);
    chk("abort_dm_we",    {31'b0, dm_we}, 32'd0);
    chk("abort_rdata",    rdata,          32'd0);
    chk("abort_dm_addr",  dm_addr,        32'd0);
    chk("abort_dm_wdata", dm_wdata,       32'd0);
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || dm_we !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("abort_quiet", {31'b0, bad}, 32'd0);
    chk("abort_mem", mem[8], 32'h11223344);
    reset = 1'b1;
    after_done = 1'b0;
    do_op("post_rst_lw", LW, 32'h20, 32'h0, lat, err, rd, we_cnt, we_data);
    chk("post_rst_lw_err", {31'b0, err}, 32'd0);
    chk("post_rst_lw_lat", lat, 32'd2);
    chk("post_rst_lw_rdata", rd, 32'h11223344);
    chk("post_rst_lw_we", we_cnt, 32'd0);
    ref_last = 32'h11223344;

    for (int unsigned i = 0; i < 64; i++) poke(i, $urandom);

    for (int n = 0; n < 150; n++) begin
      logic [2:0]  o;
      logic [31:0] a, wd, v, e_word;
      int unsigned ab, sz, base, e_lat, e_we;
      logic        e_err, is_ld;
      string       nm;
      nm = $sformatf("r%0d", n);
      o  = 3'($urandom_range(0, 7));
      a  = $urandom;
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        after_done = 1'b0;
      end
      ab    = int'(a[7:0]);
      sz    = (o == LW || o == SW) ? 4 : (o == LH || o == LHU || o == SH) ? 2 : 1;
      e_err = (ab % sz) != 0;
      is_ld = (o < SW);
      base  = ab - (ab % 4);
      e_lat = e_err ? 1 : (o == SH || o == SB) ? 3 : 2;
      e_we  = (!e_err && !is_ld) ? 1 : 0;
      if (!e_err && is_ld) begin
        v = '0;
        for (int unsigned k = 0; k < sz; k++) v = v | (32'(rb[ab + k]) << (8 * k));
        if ((o == LH || o == LB) && v[8*sz - 1]) v = v | (32'hFFFFFFFF << (8 * sz));
        ref_last = v;
      end
      if (!e_err && !is_ld)
        for (int unsigned k = 0; k < sz; k++) rb[ab + k] = wd[8*k +: 8];
      e_word = rb_word(base);
      do_op(nm, o, a, wd, lat, err, rd, we_cnt, we_data);
      chk({nm, "_addr_err"}, {31'b0, err}, {31'b0, e_err});
      chk({nm, "_latency"}, lat, e_lat);
      chk({nm, "_rdata"}, rd, ref_last);
      chk({nm, "_we_cycles"}, we_cnt, e_we);
      if (e_we != 0) chk({nm, "_dm_wdata"}, we_data, e_word);
      chk({nm, "_mem_word"}, mem[base / 4], e_word);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
